// File: rtl/sad_search_controller_if.sv
// Bus between the SAD search controller and its environment: CPU configuration,
// paired frame/window pixel reads, and the search result.
interface sad_search_controller_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
);
  logic              Start;
  logic [DIM_W-1:0]  FrameWidth;
  logic [DIM_W-1:0]  FrameHeight;
  logic [DIM_W-1:0]  MemWidth;
  logic [DIM_W-1:0]  MemHeight;
  logic [ADDR_W-1:0] FrameBase;
  logic [ADDR_W-1:0] WindowBase;
  logic              FrameRdEn;
  logic [ADDR_W-1:0] FrameAddr;
  logic              WinRdEn;
  logic [ADDR_W-1:0] WinAddr;
  logic [DATA_W-1:0] FramePix;
  logic [DATA_W-1:0] WinPix;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [31:0]       MinSAD;
  logic [DIM_W-1:0]  MinX;
  logic [DIM_W-1:0]  MinY;

  modport master (
    input  Start, FrameWidth, FrameHeight, MemWidth, MemHeight, FrameBase, WindowBase,
    input  FramePix, WinPix,
    output FrameRdEn, FrameAddr, WinRdEn, WinAddr,
    output Busy, Done, Error, MinSAD, MinX, MinY
  );

  modport slave (
    output Start, FrameWidth, FrameHeight, MemWidth, MemHeight, FrameBase, WindowBase,
    output FramePix, WinPix,
    input  FrameRdEn, FrameAddr, WinRdEn, WinAddr,
    input  Busy, Done, Error, MinSAD, MinX, MinY
  );
endinterface

// File: rtl/sad_search_controller.sv
// Full-search SAD motion estimation sequencer: scans every window position in the
// frame, accumulates |frame-window| per position and keeps the first minimum.
module sad_search_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  sad_search_controller_if.master bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    DRAIN   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DIM_W-1:0]  r_fw, r_fh, r_mw, r_mh;
  logic [DIM_W-1:0]  r_x, r_y, r_i, r_j;
  logic [DIM_W-1:0]  r_min_x, r_min_y;
  logic [ADDR_W-1:0] r_wbase, r_pos, r_faddr, r_waddr;
  logic [31:0]       r_acc, r_min_sad;
  logic              r_rd, r_pend, r_busy, r_done, r_err;

  logic              w_cfg_bad, w_last_i, w_last_j, w_last_x, w_last_y;
  logic [DATA_W-1:0] w_diff;
  logic [32:0]       w_sum;
  logic [ADDR_W-1:0] w_pos_next;

  assign w_cfg_bad = (bus.MemWidth == DIM_W'(0)) || (bus.MemHeight == DIM_W'(0)) ||
                     (bus.MemWidth > bus.FrameWidth) || (bus.MemHeight > bus.FrameHeight);
  assign w_last_i  = (r_i == r_mw - DIM_W'(1));
  assign w_last_j  = (r_j == r_mh - DIM_W'(1));
  assign w_last_x  = (r_x == r_fw - r_mw);
  assign w_last_y  = (r_y == r_fh - r_mh);
  assign w_diff    = (bus.FramePix >= bus.WinPix) ? (bus.FramePix - bus.WinPix)
                                                  : (bus.WinPix - bus.FramePix);
  assign w_sum     = {1'b0, r_acc} + 33'(w_diff);
  // Moving from the rightmost position to the next row start is a +MemWidth step.
  assign w_pos_next = w_last_x ? (r_pos + ADDR_W'(r_mw)) : (r_pos + ADDR_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_state_next = w_cfg_bad ? DONE : SCAN;
        end else begin
          w_state_next = IDLE;
        end
      end
      SCAN: begin
        if (w_last_i && w_last_j) begin
          w_state_next = DRAIN;
        end else begin
          w_state_next = SCAN;
        end
      end
      DRAIN:   w_state_next = COMPARE;
      COMPARE: begin
        if (w_last_x && w_last_y) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SCAN;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fw <= '0; r_fh <= '0; r_mw <= '0; r_mh <= '0;
      r_x <= '0; r_y <= '0; r_i <= '0; r_j <= '0;
      r_min_x <= '0; r_min_y <= '0;
      r_wbase <= '0; r_pos <= '0; r_faddr <= '0; r_waddr <= '0;
      r_acc <= 32'd0; r_min_sad <= 32'hFFFF_FFFF;
      r_rd <= 1'b0; r_pend <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_pend <= r_rd;
      r_busy <= (w_state_next == SCAN) || (w_state_next == DRAIN) || (w_state_next == COMPARE);
      r_done <= (w_state_next == DONE);
      // Pixel data returns one cycle after its read strobe.
      if (r_pend) begin
        r_acc <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
      end
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_fw <= bus.FrameWidth; r_fh <= bus.FrameHeight;
            r_mw <= bus.MemWidth;   r_mh <= bus.MemHeight;
            r_wbase <= bus.WindowBase;
            r_pos <= bus.FrameBase; r_faddr <= bus.FrameBase; r_waddr <= bus.WindowBase;
            r_x <= '0; r_y <= '0; r_i <= '0; r_j <= '0;
            r_acc <= 32'd0; r_min_sad <= 32'hFFFF_FFFF;
            r_min_x <= '0; r_min_y <= '0;
            r_err <= w_cfg_bad;
            r_rd <= !w_cfg_bad;
          end
        end
        SCAN: begin
          if (!w_last_i) begin
            r_i <= r_i + DIM_W'(1);
            r_faddr <= r_faddr + ADDR_W'(1);
            r_waddr <= r_waddr + ADDR_W'(1);
          end else if (!w_last_j) begin
            r_i <= '0;
            r_j <= r_j + DIM_W'(1);
            r_faddr <= r_faddr + ADDR_W'(r_fw) - ADDR_W'(r_mw) + ADDR_W'(1);
            r_waddr <= r_waddr + ADDR_W'(1);
          end else begin
            r_rd <= 1'b0;
          end
        end
        COMPARE: begin
          if (r_acc < r_min_sad) begin
            r_min_sad <= r_acc;
            r_min_x <= r_x;
            r_min_y <= r_y;
          end
          r_acc <= 32'd0; r_i <= '0; r_j <= '0;
          r_pos <= w_pos_next;
          if (w_last_x) begin
            r_x <= '0;
            r_y <= r_y + DIM_W'(1);
          end else begin
            r_x <= r_x + DIM_W'(1);
          end
          if (!(w_last_x && w_last_y)) begin
            r_faddr <= w_pos_next;
            r_waddr <= r_wbase;
            r_rd <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.FrameRdEn = r_rd;
  assign bus.WinRdEn   = r_rd;
  assign bus.FrameAddr = r_faddr;
  assign bus.WinAddr   = r_waddr;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Error     = r_err;
  assign bus.MinSAD    = r_min_sad;
  assign bus.MinX      = r_min_x;
  assign bus.MinY      = r_min_y;
endmodule

// File: tb/tb_sad_search_controller.sv
// Scoreboard bench for sad_search_controller: directed searches push expected
// results; a negedge monitor checks them when Done pulses.
module tb_sad_search_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   rd_cnt = 0;
  int   s_cyc = 0;
  logic [31:0] fbase = 32'd0;
  logic [31:0] wbase = 32'd0;
  logic [7:0]  fmem [64];
  logic [7:0]  wmem [64];

  typedef struct {
    logic [31:0] sad;
    logic [15:0] x;
    logic [15:0] y;
    logic        err;
    int          dcyc;
  } exp_t;
  typedef struct {
    logic [31:0] fa;
    logic [31:0] wa;
  } addr_t;
  exp_t  sb[$];
  addr_t aq[$];

  sad_search_controller_if bus ();

  sad_search_controller dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memories answer one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.FrameRdEn) bus.FramePix <= fmem[6'(bus.FrameAddr - fbase)];
    if (bus.WinRdEn)   bus.WinPix   <= wmem[6'(bus.WinAddr - wbase)];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read addresses and completion results.
  always @(negedge clk) begin
    if (bus.FrameRdEn) begin
      rd_cnt++;
      if (aq.size() > 0) begin
        addr_t a;
        a = aq.pop_front();
        chk("frame_addr", 64'(bus.FrameAddr), 64'(a.fa));
        chk("win_addr", 64'(bus.WinAddr), 64'(a.wa));
      end
    end
    if (bus.Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(bus.Done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("min_sad", 64'(bus.MinSAD), 64'(e.sad));
        chk("min_x", 64'(bus.MinX), 64'(e.x));
        chk("min_y", 64'(bus.MinY), 64'(e.y));
        chk("error", 64'(bus.Error), 64'(e.err));
        chk("done_cycle", 64'(cyc), 64'(e.dcyc));
        chk("busy_at_done", 64'(bus.Busy), 64'd0);
      end
    end
  end

  task automatic start(input logic [15:0] fw, input logic [15:0] fh,
                       input logic [15:0] mw, input logic [15:0] mh);
    @(negedge clk);
    bus.FrameWidth = fw; bus.FrameHeight = fh;
    bus.MemWidth = mw;   bus.MemHeight = mh;
    bus.FrameBase = fbase; bus.WindowBase = wbase;
    bus.Start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic push(input logic [31:0] sad, input logic [15:0] x, input logic [15:0] y,
                      input logic err, input int rel);
    exp_t e;
    e.sad = sad; e.x = x; e.y = y; e.err = err; e.dcyc = s_cyc + rel;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic load_case1();
    fbase = 32'd0; wbase = 32'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) fmem[r*4+c] = 8'(4*r + c);
    wmem[0] = 8'd6; wmem[1] = 8'd7; wmem[2] = 8'd10; wmem[3] = 8'd11;
  endtask

  initial begin
    int rd_before;
    bus.Start = 1'b0;
    bus.FrameWidth = 16'd0; bus.FrameHeight = 16'd0;
    bus.MemWidth = 16'd0;   bus.MemHeight = 16'd0;
    bus.FrameBase = 32'd0;  bus.WindowBase = 32'd0;
    for (int k = 0; k < 64; k++) begin
      fmem[k] = 8'd0; wmem[k] = 8'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_rden", 64'({bus.FrameRdEn, bus.WinRdEn}), 64'd0);
    chk("rst_addr", {bus.FrameAddr, bus.WinAddr}, 64'd0);
    chk("rst_done_err", 64'({bus.Done, bus.Error}), 64'd0);
    chk("rst_minsad", 64'(bus.MinSAD), 64'hFFFF_FFFF);
    chk("rst_minxy", 64'({bus.MinX, bus.MinY}), 64'd0);
    rst = 1'b0;

    // Case 1: 4x4 ramp frame, exact match at (2,1).
    load_case1();
    aq.push_back('{32'd0, 32'd0}); aq.push_back('{32'd1, 32'd1});
    aq.push_back('{32'd4, 32'd2}); aq.push_back('{32'd5, 32'd3});
    start(16'd4, 16'd4, 16'd2, 16'd2);
    push(32'd0, 16'd2, 16'd1, 1'b0, 55);
    wait_done(200);
    chk("addr_queue_drained", 64'(aq.size()), 64'd0);

    // Case 2: single position with non-zero bases, SAD 9*2.
    fbase = 32'd200; wbase = 32'd50;
    for (int k = 0; k < 9; k++) begin
      fmem[k] = 8'd10; wmem[k] = 8'd12;
    end
    start(16'd3, 16'd3, 16'd3, 16'd3);
    push(32'd18, 16'd0, 16'd0, 1'b0, 12);
    wait_done(100);

    // Error cases: no reads, Done at cycle 1, Error held afterwards.
    rd_before = rd_cnt;
    start(16'd4, 16'd4, 16'd0, 16'd2);
    push(32'hFFFF_FFFF, 16'd0, 16'd0, 1'b1, 1);
    wait_done(20);
    start(16'd4, 16'd4, 16'd2, 16'd5);
    push(32'hFFFF_FFFF, 16'd0, 16'd0, 1'b1, 1);
    wait_done(20);
    chk("err_no_reads", 64'(rd_cnt), 64'(rd_before));
    repeat (3) @(negedge clk);
    chk("err_held", 64'(bus.Error), 64'd1);

    // Tie: all three positions score 4, first wins.
    fbase = 32'd0; wbase = 32'd0;
    for (int k = 0; k < 4; k++) fmem[k] = 8'd5;
    wmem[0] = 8'd7; wmem[1] = 8'd7;
    start(16'd4, 16'd1, 16'd2, 16'd1);
    push(32'd4, 16'd0, 16'd0, 1'b0, 13);
    wait_done(100);

    // Reset in the middle of a scan, after a finite minimum exists.
    load_case1();
    start(16'd4, 16'd4, 16'd2, 16'd2);
    repeat (19) @(negedge clk);
    chk("busy_before_reset", 64'(bus.Busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    chk("midrst_rden", 64'({bus.FrameRdEn, bus.WinRdEn}), 64'd0);
    chk("midrst_minsad", 64'(bus.MinSAD), 64'hFFFF_FFFF);
    rst = 1'b0;
    start(16'd4, 16'd4, 16'd2, 16'd2);
    push(32'd0, 16'd2, 16'd1, 1'b0, 55);
    wait_done(200);

    // Start re-pulsed while busy with other dimensions is ignored.
    start(16'd4, 16'd4, 16'd2, 16'd2);
    push(32'd0, 16'd2, 16'd1, 1'b0, 55);
    repeat (8) @(negedge clk);
    bus.FrameWidth = 16'd3; bus.FrameHeight = 16'd3;
    bus.MemWidth = 16'd3;   bus.MemHeight = 16'd3;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(200);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
